// File: rtl/lsu_mem_sequencer.sv
// Load/store sequencer between the core and a wait-stated 32-bit data memory.
// Generates byte lanes, splits word-crossing accesses and merges/extends load data.
module lsu_mem_sequencer #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned SPLIT_EN   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  stall,
  output logic                  busy,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_ready,
  input  logic [31:0]           mem_rdata
);

  typedef enum logic [1:0] {StIdle, StAcc0, StAcc1, StDone} state_e;

  localparam bit SplitOn = (SPLIT_EN != 0);

  state_e                  state_q, state_d;
  logic                    mem_req_q, mem_req_d;
  logic                    mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [3:0]              mem_be_q, mem_be_d;
  logic [31:0]             mem_wdata_q, mem_wdata_d;
  logic                    resp_valid_q, resp_valid_d;
  logic [31:0]             resp_rdata_q, resp_rdata_d;
  logic                    resp_err_q, resp_err_d;
  logic                    busy_q, busy_d;

  // Access attributes latched at acceptance; req_* is not relied on afterwards.
  logic [1:0]              off_q, off_d;
  logic [2:0]              size_q, size_d;
  logic                    sext_q, sext_d;
  logic                    split_q, split_d;
  logic                    write_q, write_d;
  logic [ADDR_WIDTH-1:0]   addr1_q, addr1_d;
  logic [3:0]              be1_q, be1_d;
  logic [31:0]             wdata1_q, wdata1_d;
  logic [31:0]             lo_q, lo_d;

  logic [2:0]              dec_size;
  logic                    dec_illegal;
  logic [1:0]              dec_off;
  logic                    dec_split;
  logic [3:0]              dec_mask;
  logic [7:0]              be_wide;
  logic [63:0]             wdata_wide;
  logic [ADDR_WIDTH-1:0]   addr0;
  logic [ADDR_WIDTH-1:0]   addr1;

  always_comb begin
    dec_size    = 3'd1;
    dec_mask    = 4'b0001;
    dec_illegal = 1'b0;
    case (req_funct3)
      3'b000, 3'b100: begin
        dec_size = 3'd1;
        dec_mask = 4'b0001;
      end
      3'b001, 3'b101: begin
        dec_size = 3'd2;
        dec_mask = 4'b0011;
      end
      3'b010: begin
        dec_size = 3'd4;
        dec_mask = 4'b1111;
      end
      default: dec_illegal = 1'b1;
    endcase
    // Unsigned variants only exist for loads.
    if (req_funct3[2] && req_write) dec_illegal = 1'b1;
  end

  assign dec_off    = req_addr[1:0];
  assign dec_split  = ({1'b0, dec_off} + dec_size) > 3'd4;
  // Upper nibble / upper word of the shifted values are the second transaction's lanes.
  assign be_wide    = {4'b0000, dec_mask} << dec_off;
  assign wdata_wide = {32'h0, req_wdata} << {dec_off, 3'b000};
  assign addr0      = {req_addr[ADDR_WIDTH-1:2], 2'b00};
  assign addr1      = addr0 + ADDR_WIDTH'(4);

  function automatic logic [31:0] merge_load(input logic [31:0] hi, input logic [31:0] lo,
                                             input logic [1:0] off, input logic [2:0] size,
                                             input logic sext);
    logic [31:0] raw;
    logic [31:0] res;
    raw = 32'({hi, lo} >> {off, 3'b000});
    case (size)
      3'd1:    res = {{24{sext & raw[7]}}, raw[7:0]};
      3'd2:    res = {{16{sext & raw[15]}}, raw[15:0]};
      default: res = raw;
    endcase
    return res;
  endfunction

  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_be_d     = mem_be_q;
    mem_wdata_d  = mem_wdata_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = 32'h0;
    resp_err_d   = 1'b0;
    off_d        = off_q;
    size_d       = size_q;
    sext_d       = sext_q;
    split_d      = split_q;
    write_d      = write_q;
    addr1_d      = addr1_q;
    be1_d        = be1_q;
    wdata1_d     = wdata1_q;
    lo_d         = lo_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (dec_illegal || (dec_split && !SplitOn)) begin
            state_d      = StDone;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            state_d     = StAcc0;
            mem_req_d   = 1'b1;
            mem_we_d    = req_write;
            mem_addr_d  = addr0;
            mem_be_d    = be_wide[3:0];
            mem_wdata_d = wdata_wide[31:0];
            off_d       = dec_off;
            size_d      = dec_size;
            sext_d      = ~req_funct3[2];
            split_d     = dec_split;
            write_d     = req_write;
            addr1_d     = addr1;
            be1_d       = be_wide[7:4];
            wdata1_d    = wdata_wide[63:32];
          end
        end
      end
      StAcc0: begin
        if (mem_ready) begin
          lo_d = mem_rdata;
          if (split_q) begin
            state_d     = StAcc1;
            mem_addr_d  = addr1_q;
            mem_be_d    = be1_q;
            mem_wdata_d = wdata1_q;
          end else begin
            state_d      = StDone;
            mem_req_d    = 1'b0;
            mem_we_d     = 1'b0;
            mem_addr_d   = '0;
            mem_be_d     = 4'b0000;
            mem_wdata_d  = 32'h0;
            resp_valid_d = 1'b1;
            resp_rdata_d = write_q ? 32'h0 : merge_load(32'h0, mem_rdata, off_q, size_q, sext_q);
          end
        end
      end
      StAcc1: begin
        if (mem_ready) begin
          state_d      = StDone;
          mem_req_d    = 1'b0;
          mem_we_d     = 1'b0;
          mem_addr_d   = '0;
          mem_be_d     = 4'b0000;
          mem_wdata_d  = 32'h0;
          resp_valid_d = 1'b1;
          resp_rdata_d = write_q ? 32'h0 : merge_load(mem_rdata, lo_q, off_q, size_q, sext_q);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= 4'b0000;
      mem_wdata_q  <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
      busy_q       <= 1'b0;
      off_q        <= 2'b00;
      size_q       <= 3'd0;
      sext_q       <= 1'b0;
      split_q      <= 1'b0;
      write_q      <= 1'b0;
      addr1_q      <= '0;
      be1_q        <= 4'b0000;
      wdata1_q     <= 32'h0;
      lo_q         <= 32'h0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_be_q     <= mem_be_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      busy_q       <= busy_d;
      off_q        <= off_d;
      size_q       <= size_d;
      sext_q       <= sext_d;
      split_q      <= split_d;
      write_q      <= write_d;
      addr1_q      <= addr1_d;
      be1_q        <= be1_d;
      wdata1_q     <= wdata1_d;
      lo_q         <= lo_d;
    end
  end

  assign stall      = req_valid & ~resp_valid_q;
  assign busy       = busy_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_be     = mem_be_q;
  assign mem_wdata  = mem_wdata_q;

endmodule
